serial_mag_comparator: RTL



---
 rtl/cmp_pkg.sv | 26 ++
 rtl/cmp_slice_2bit.sv | 14 +
 rtl/serial_mag_comparator.sv | 114 +++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
// Results are one-hot {lout,gout,eout}.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [2:0] res_t;

  localparam res_t RES_LT = 3'b100;
  localparam res_t RES_GT = 3'b010;
  localparam res_t RES_EQ = 3'b001;

  function automatic int nslice(input int width);
    return width / 2;
  endfunction

  // A one-slice compare still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmp_slice_2bit.sv
// Combinational 2-bit unsigned magnitude compare of one operand slice.
module cmp_slice_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       lt,
  output logic       gt,
  output logic       eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_mag_comparator.sv
// Serial magnitude comparator: consumes WIDTH-bit operands as 2-bit slices, MSB first.
// Optional macro SIGNED_CMP_EN: two's-complement compare (sign bit flipped on slice 0).
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       lin,
  input  logic       gin,
  input  logic       ein,
  input  logic       slice_valid,
  input  logic [1:0] x_slice,
  input  logic [1:0] y_slice,
  output logic       slice_ready,
  output logic       busy,
  output logic       done,
  output logic       lout,
  output logic       gout,
  output logic       eout
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int CW     = cnt_width(NSLICE);
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  res_t          run_q, run_next, res_q;
  logic          accept, last_slice;
  logic [1:0]    xs, ys;
  logic          s_lt, s_gt, s_eq;

  assign accept     = (state_q == RUN) && slice_valid;
  assign last_slice = accept && (cnt_q == LAST);

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit of the MSB slice maps two's complement onto unsigned order.
  always_comb begin
    xs = x_slice;
    ys = y_slice;
    if (cnt_q == '0) begin
      xs[1] = ~x_slice[1];
      ys[1] = ~y_slice[1];
    end
  end
`else
  assign xs = x_slice;
  assign ys = y_slice;
`endif

  cmp_slice_2bit u_slice (
    .a  (xs),
    .b  (ys),
    .lt (s_lt),
    .gt (s_gt),
    .eq (s_eq)
  );

  always_comb begin
    run_next = run_q;
    if (run_q == RES_EQ) begin
      if (s_lt)      run_next = RES_LT;
      else if (s_gt) run_next = RES_GT;
      else if (s_eq) run_next = RES_EQ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slice_ready = (state_q == RUN);
    busy        = (state_q == RUN) || (state_q == DONE);
    done        = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= RES_EQ;
      res_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cnt_q <= '0;
        if (lin)      run_q <= RES_LT;
        else if (gin) run_q <= RES_GT;
        else          run_q <= RES_EQ;
      end
      if (accept) begin
        cnt_q <= cnt_q + CW'(1);
        run_q <= run_next;
      end
      if (last_slice) res_q <= run_next;
    end
  end

  assign {lout, gout, eout} = res_q;

endmodule
